// File: rtl/rob_tag_ctrl_if.sv
// Issue, CDB writeback and commit signal bundle between decode/issue, the
// functional units, the regfile and the ROB tag controller.
interface rob_tag_ctrl_if #(
  parameter int ROB_DEPTH = 4
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic             issue_req;
  logic [4:0]       issue_rd_s;
  logic             issue_regf_we;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             rob_commit;
  logic             rob_commit_regf_we;
  logic [4:0]       rob_commit_rd_s;
  logic [31:0]      rob_commit_rd_v;
  logic [TAG_W-1:0] rob_commit_tag;

  modport master (
    output issue_req, issue_rd_s, issue_regf_we,
    output cdb_valid, cdb_tag, cdb_value,
    input  issue_ready, issue_tag,
    input  rob_commit, rob_commit_regf_we, rob_commit_rd_s, rob_commit_rd_v, rob_commit_tag
  );

  modport slave (
    input  issue_req, issue_rd_s, issue_regf_we,
    input  cdb_valid, cdb_tag, cdb_value,
    output issue_ready, issue_tag,
    output rob_commit, rob_commit_regf_we, rob_commit_rd_s, rob_commit_rd_v, rob_commit_tag
  );
endinterface

// File: rtl/rob_tag_ctrl.sv
// Reorder-buffer tag controller: allocates tags at issue, records CDB completion,
// retires in order. Define ROB_COMMIT_BYPASS_EN to let a CDB hit on the head commit at once.
module rob_tag_ctrl #(
  parameter int ROB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  rob_tag_ctrl_if.slave               bus,
  output logic [$clog2(ROB_DEPTH):0]  rob_count,
  output logic                        flush_busy
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  typedef logic [TAG_W:0]   ptr_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef enum logic { ST_RUN, ST_FLUSH } state_t;

  state_t                 state;
  ptr_t                   head;
  ptr_t                   tail;
  logic [ROB_DEPTH-1:0]   valid;
  logic [ROB_DEPTH-1:0]   done;
  logic [ROB_DEPTH-1:0]   regf_we_q;
  logic [4:0]             rd_s_q  [ROB_DEPTH];
  logic [31:0]            value_q [ROB_DEPTH];

  tag_t head_idx;
  tag_t tail_idx;
  logic full;
  logic run_ok;
  logic issue_fire;
  logic cdb_fire;
  logic bypass_hit;
  logic commit_fire;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];

  // Wrap bits differ with equal indices: tail has lapped head exactly once.
  assign full   = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign run_ok = (state == ST_RUN) && !flush;

  assign issue_fire = bus.issue_req && bus.issue_ready;
  assign cdb_fire   = bus.cdb_valid && run_ok && valid[bus.cdb_tag];

`ifdef ROB_COMMIT_BYPASS_EN
  assign bypass_hit = valid[head_idx] && !done[head_idx] && bus.cdb_valid &&
                      (bus.cdb_tag == head_idx) && run_ok;
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_fire = (valid[head_idx] && done[head_idx] && run_ok) || bypass_hit;

  assign bus.issue_ready    = !full && run_ok;
  assign bus.issue_tag      = tail_idx;
  assign bus.rob_commit     = commit_fire;
  assign bus.rob_commit_tag = head_idx;
  assign rob_count          = tail - head;

  // NOTE: every output written here gets a default first so no latch is inferred.
  always_comb begin
    bus.rob_commit_regf_we = 1'b0;
    bus.rob_commit_rd_s    = '0;
    bus.rob_commit_rd_v    = '0;
    if (commit_fire) begin
      bus.rob_commit_regf_we = regf_we_q[head_idx];
      bus.rob_commit_rd_s    = rd_s_q[head_idx];
      bus.rob_commit_rd_v    = bypass_hit ? bus.cdb_value : value_q[head_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_busy <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state      <= ST_FLUSH;
            flush_busy <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush) begin
            state      <= ST_FLUSH;
            flush_busy <= 1'b1;
          end else begin
            state      <= ST_RUN;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy bookkeeping. Issue and CDB never target the same slot (the tail
  // slot is invalid unless full), and issue/commit only share a slot when the
  // ROB is full or empty, where one of them is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (issue_fire) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
        tail            <= tail + ptr_t'(1);
      end
      if (cdb_fire) begin
        done[bus.cdb_tag] <= 1'b1;
      end
      if (commit_fire) begin
        valid[head_idx] <= 1'b0;
        head            <= head + ptr_t'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; it is only observed through
  // valid-gated commit outputs, and every allocation rewrites it.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      regf_we_q[tail_idx] <= bus.issue_regf_we;
      rd_s_q[tail_idx]    <= bus.issue_rd_s;
      value_q[tail_idx]   <= '0;
    end
    if (cdb_fire) begin
      value_q[bus.cdb_tag] <= bus.cdb_value;
    end
  end

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// Directed and randomized bench for rob_tag_ctrl against an in-order queue model
// of the reorder buffer.
module tb_rob_tag_ctrl;
  localparam int D  = 4;
  localparam int TW = $clog2(D);
`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [TW:0]   rob_count;
  logic          flush_busy;

  rob_tag_ctrl_if #(.ROB_DEPTH(D)) bus ();

  rob_tag_ctrl #(.ROB_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .rob_count  (rob_count),
    .flush_busy (flush_busy)
  );

  always #5 clk = ~clk;

  // Model: in-flight instructions in program order; q[0] is the oldest.
  typedef struct {
    logic [4:0]  rd;
    bit          we;
    bit          done;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  int   m_head;
  bit   m_flush_st;
  int   checks;
  int   errors;
  int   log_tags[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit m_run();
    return !m_flush_st && !flush;
  endfunction

  function automatic bit m_bypass();
    if (!BYP || q.size() == 0) return 1'b0;
    return !q[0].done && bus.cdb_valid && (int'(bus.cdb_tag) == m_head % D) && m_run();
  endfunction

  function automatic bit m_commit();
    if (q.size() == 0) return 1'b0;
    return m_run() && (q[0].done || m_bypass());
  endfunction

  task automatic drive(input bit fl, input bit iq, input int rd, input bit we,
                       input bit cv, input int ct, input logic [31:0] cval);
    bit          c;
    logic [31:0] e_we, e_rd, e_rdv;
    flush             = fl;
    bus.issue_req     = iq;
    bus.issue_rd_s    = 5'(rd);
    bus.issue_regf_we = we;
    bus.cdb_valid     = cv;
    bus.cdb_tag       = TW'(ct);
    bus.cdb_value     = cval;
    #1;
    c     = m_commit();
    e_we  = '0;
    e_rd  = '0;
    e_rdv = '0;
    if (c) begin
      e_we  = 32'(q[0].we);
      e_rd  = 32'(q[0].rd);
      e_rdv = q[0].done ? q[0].value : bus.cdb_value;
    end
    check("issue_ready", 32'(bus.issue_ready), 32'(q.size() < D && m_run()));
    check("issue_tag",   32'(bus.issue_tag),   32'((m_head + q.size()) % D));
    check("rob_commit",  32'(bus.rob_commit),  32'(c));
    check("commit_we",   32'(bus.rob_commit_regf_we), e_we);
    check("commit_rd_s", 32'(bus.rob_commit_rd_s),    e_rd);
    check("commit_rd_v", bus.rob_commit_rd_v,         e_rdv);
    check("commit_tag",  32'(bus.rob_commit_tag),     32'(m_head % D));
    check("rob_count",   32'(rob_count),  32'(q.size()));
    check("flush_busy",  32'(flush_busy), 32'(m_flush_st));
    if (bus.rob_commit) log_tags.push_back(int'(bus.rob_commit_tag));
  endtask

  task automatic tick();
    bit com, grant;
    int p;
    com   = m_commit();
    grant = bus.issue_req && m_run() && (q.size() < D);
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_head     = 0;
      m_flush_st = 1'b1;
    end else if (m_flush_st) begin
      m_flush_st = 1'b0;
    end else begin
      if (bus.cdb_valid) begin
        p = (int'(bus.cdb_tag) - (m_head % D) + D) % D;
        if (p < q.size()) begin
          q[p].done  = 1'b1;
          q[p].value = bus.cdb_value;
        end
      end
      if (com) begin
        q.delete(0);
        m_head++;
      end
      if (grant) q.push_back('{rd: bus.issue_rd_s, we: bus.issue_regf_we, done: 1'b0, value: 32'h0});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_flush();
    drive(1, 0, 0, 0, 0, 0, 32'h0); tick();
    idle(); tick();
  endtask

  task automatic do_reset();
    flush = 1'b0;
    bus.issue_req = 1'b0; bus.issue_rd_s = '0; bus.issue_regf_we = 1'b0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
    rst_n = 1'b0;
    q.delete();
    m_head     = 0;
    m_flush_st = 1'b0;
    #1;
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_issue_tag",   32'(bus.issue_tag),   32'd0);
    check("rst_commit",      32'(bus.rob_commit),  32'd0);
    check("rst_commit_we",   32'(bus.rob_commit_regf_we), 32'd0);
    check("rst_commit_rd_s", 32'(bus.rob_commit_rd_s),    32'd0);
    check("rst_commit_rd_v", bus.rob_commit_rd_v,         32'd0);
    check("rst_commit_tag",  32'(bus.rob_commit_tag),     32'd0);
    check("rst_count",       32'(rob_count),  32'd0);
    check("rst_flush_busy",  32'(flush_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // Fill: tags 0..3, then full.
    for (int i = 0; i < D; i++) begin
      drive(0, 1, i, 1, 0, 0, 32'h0);
      check("fill_tag", 32'(bus.issue_tag), i);
      tick();
    end
    drive(0, 1, 9, 1, 0, 0, 32'h0);
    check("full_ready", 32'(bus.issue_ready), 32'd0);
    check("full_count", 32'(rob_count), 32'd4);
    tick();
    do_flush();

    // Single instruction round trip.
    drive(0, 1, 5, 1, 0, 0, 32'h0);
    check("rt_tag", 32'(bus.issue_tag), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    check("rt_cdb_cycle_commit", 32'(bus.rob_commit), 32'(BYP));
    if (BYP) check("rt_bypass_rd_v", bus.rob_commit_rd_v, 32'hDEADBEEF);
    tick();
    if (!BYP) begin
      idle();
      check("rt_commit",  32'(bus.rob_commit), 32'd1);
      check("rt_rd_s",    32'(bus.rob_commit_rd_s), 32'd5);
      check("rt_rd_v",    bus.rob_commit_rd_v, 32'hDEADBEEF);
      check("rt_tag0",    32'(bus.rob_commit_tag), 32'd0);
      check("rt_we",      32'(bus.rob_commit_regf_we), 32'd1);
      tick();
    end
    idle();
    check("rt_count0", 32'(rob_count), 32'd0);
    tick();

    // Out-of-order completion, in-order retirement (head is now 1).
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 10 + i, 1, 0, 0, 32'h0); tick();
    end
    log_tags.delete();
    drive(0, 0, 0, 0, 1, 3, 32'h3333); tick();
    drive(0, 0, 0, 0, 1, 2, 32'h2222); tick();
    drive(0, 0, 0, 0, 1, 1, 32'h1111); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
    end
    check("ooo_ncommits", log_tags.size(), 32'd3);
    for (int i = 0; i < 3 && i < log_tags.size(); i++)
      check("ooo_order", log_tags[i], 32'(i + 1));

    // Full ROB, commit and issue collide; freed slot issuable next cycle.
    do_flush();
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 20 + i, 1, 0, 0, 32'h0); tick();
    end
    drive(0, 0, 0, 0, 1, 1, 32'hAAAA); tick();
    drive(0, 1, 30, 1, 1, 0, 32'hBBBB);
    if (!BYP) begin
      check("fc_no_commit_yet", 32'(bus.rob_commit), 32'd0);
      tick();
      drive(0, 1, 30, 1, 0, 0, 32'h0);
    end
    check("fc_commit",     32'(bus.rob_commit),     32'd1);
    check("fc_ready0",     32'(bus.issue_ready),    32'd0);
    check("fc_commit_tag", 32'(bus.rob_commit_tag), 32'd0);
    tick();
    drive(0, 1, 30, 1, 0, 0, 32'h0);
    check("fc_ready1",  32'(bus.issue_ready),    32'd1);
    check("fc_wrap_tag", 32'(bus.issue_tag),     32'd0);
    check("fc_head1",   32'(bus.rob_commit_tag), 32'd1);
    tick();

    // Flush with three in flight; CDB during FLUSH ignored.
    do_flush();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4 + i, 1, 0, 0, 32'h0); tick();
    end
    drive(1, 0, 0, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 1, 0, 32'h5555);
    check("fl_busy",   32'(flush_busy),      32'd1);
    check("fl_ready0", 32'(bus.issue_ready), 32'd0);
    check("fl_count0", 32'(rob_count),       32'd0);
    check("fl_commit", 32'(bus.rob_commit),  32'd0);
    tick();
    idle();
    check("fl_tag0",    32'(bus.issue_tag), 32'd0);
    check("fl_busy_off", 32'(flush_busy),   32'd0);
    check("fl_count",   32'(rob_count),     32'd0);
    tick();

    // Mid-operation reset.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 7, 1, 0, 0, 32'h0); tick();
    end
    drive(0, 0, 0, 0, 1, 0, 32'h7777); tick();
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, int'($urandom_range(0, D - 1)),
            $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
